// File: rtl/prot_pkg.sv
// Shared constants and types for the 8N1 command-frame receiver.
package prot_pkg;

  // First byte of every command frame
  localparam logic [7:0] HDR_BYTE  = 8'hAA;
  // Bytes per frame: header, cmd, d3, d2, d1, d0
  localparam int         FRAME_LEN = 6;

  // Abort cause codes reported on ecode
  localparam logic [1:0] E_FRM = 2'd1;  // stop bit sampled low
  localparam logic [1:0] E_HDR = 2'd2;  // first byte was not the header
  localparam logic [1:0] E_TMO = 2'd3;  // line idle too long inside a frame

  // Byte-level receive state
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } byte_st_t;

endpackage

// File: rtl/prot_rxb.sv
// Byte receiver: 2-flop synchroniser on the serial line plus the 8N1 byte FSM.
// Emits a one-cycle bval with bdat on a good stop bit, or a one-cycle berr
// when the stop bit is low. After a framing error the start detector stays
// disarmed until the line returns high, so a held-low break is reported once.
module prot_rxb
  import prot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208
) (
  input  logic       ck,
  input  logic       rst_n,
  input  logic       rx,
  output logic       bval,
  output logic [7:0] bdat,
  output logic       berr,
  output logic       bact
);

  localparam int            CW     = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] C_FULL = CW'(CLKS_PER_BIT - 1);

  logic          r_sync1;
  logic          r_rxs;
  byte_st_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic [7:0]    r_shift;
  logic          r_armed;
  logic          r_bval;
  logic [7:0]    r_bdat;
  logic          r_berr;

  // Two-flop synchroniser; idles high so reset does not look like a start bit
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_rxs   <= r_sync1;
    end
  end

  // Byte FSM: mid-bit sampling driven by a down-counter reloaded every bit
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_armed <= 1'b0;
      r_bval  <= 1'b0;
      r_bdat  <= '0;
      r_berr  <= 1'b0;
    end else begin
      r_bval <= 1'b0;
      r_berr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (!r_armed) begin
            if (r_rxs) r_armed <= 1'b1;
          end else if (!r_rxs) begin
            r_state <= ST_START;
            r_cnt   <= C_HALF;
          end
        end
        ST_START: begin
          if (r_cnt == '0) begin
            if (r_rxs) begin
              r_state <= ST_IDLE;          // glitch, not a real start bit
            end else begin
              r_state <= ST_DATA;
              r_cnt   <= C_FULL;
              r_bit   <= '0;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_DATA: begin
          if (r_cnt == '0) begin
            r_shift <= {r_rxs, r_shift[7:1]};  // LSB arrives first
            r_cnt   <= C_FULL;
            if (r_bit == 3'd7) r_state <= ST_STOP;
            else               r_bit   <= r_bit + 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_STOP: begin
          if (r_cnt == '0) begin
            r_state <= ST_IDLE;
            if (r_rxs) begin
              r_bval <= 1'b1;
              r_bdat <= r_shift;
            end else begin
              r_berr  <= 1'b1;
              r_armed <= 1'b0;             // wait for line high before next start
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bval = r_bval;
  assign bdat = r_bdat;
  assign berr = r_berr;
  assign bact = (r_state != ST_IDLE);

endmodule

// File: rtl/prot_rx.sv
// Command-frame receiver: assembles AA,cmd,d3,d2,d1,d0 from the byte
// receiver, publishes good frames with a one-cycle fok and reports
// framing / header / inter-byte timeout aborts with a one-cycle ferr.
module prot_rx
  import prot_pkg::*;
#(
  parameter int CLKS_PER_BIT = 5208,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        Rx,
  output logic [7:0]  fcmd,
  output logic [31:0] fdat,
  output logic        fok,
  output logic        ferr,
  output logic [1:0]  ecode,
  output logic        busy
);

  localparam int            DW     = $clog2(CLKS_PER_BIT);
  localparam int            TW     = $clog2(TIMEOUT_BITS + 1);
  localparam logic [DW-1:0] D_LAST = DW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT_BITS);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_BITS - 1);
  localparam logic [2:0]    I_LAST = 3'(FRAME_LEN - 1);

  logic        w_bval;
  logic [7:0]  w_bdat;
  logic        w_berr;
  logic        w_bact;
  logic        w_run;
  logic        w_tmo;

  logic [2:0]    r_idx;
  logic [7:0]    r_cmd_sh;
  logic [23:0]   r_dat_sh;
  logic [DW-1:0] r_tdiv;
  logic [TW-1:0] r_tcnt;
  logic [7:0]    r_fcmd;
  logic [31:0]   r_fdat;
  logic          r_fok;
  logic          r_ferr;
  logic [1:0]    r_ecode;

  prot_rxb #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rxb (
    .ck   (ck),
    .rst_n(rst_n),
    .rx   (Rx),
    .bval (w_bval),
    .bdat (w_bdat),
    .berr (w_berr),
    .bact (w_bact)
  );

  // Idle time is only counted between bytes of a partially received frame
  assign w_run = (r_idx != '0) && !w_bact;
  assign w_tmo = w_run && (r_tdiv == D_LAST) && (r_tcnt == T_LAST);

  // Inter-byte idle timer: bit-time prescaler plus saturating bit-time count
  always_ff @(posedge ck) begin
    if (!rst_n || !w_run) begin
      r_tdiv <= '0;
      r_tcnt <= '0;
    end else if (r_tdiv == D_LAST) begin
      r_tdiv <= '0;
      if (r_tcnt != T_MAX) r_tcnt <= r_tcnt + 1'b1;
    end else begin
      r_tdiv <= r_tdiv + 1'b1;
    end
  end

  // Frame assembly and output registers; byte events take priority over timeout
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_cmd_sh <= '0;
      r_dat_sh <= '0;
      r_fcmd   <= '0;
      r_fdat   <= '0;
      r_fok    <= 1'b0;
      r_ferr   <= 1'b0;
      r_ecode  <= '0;
    end else begin
      r_fok  <= 1'b0;
      r_ferr <= 1'b0;
      if (w_berr) begin
        r_ferr  <= 1'b1;
        r_ecode <= E_FRM;
        r_idx   <= '0;
      end else if (w_bval) begin
        if (r_idx == '0) begin
          if (w_bdat == HDR_BYTE) begin
            r_idx <= 3'd1;
          end else begin
            r_ferr  <= 1'b1;
            r_ecode <= E_HDR;
          end
        end else if (r_idx == 3'd1) begin
          r_cmd_sh <= w_bdat;
          r_idx    <= 3'd2;
        end else if (r_idx == I_LAST) begin
          r_fcmd <= r_cmd_sh;
          r_fdat <= {r_dat_sh, w_bdat};
          r_fok  <= 1'b1;
          r_idx  <= '0;
        end else begin
          r_dat_sh <= {r_dat_sh[15:0], w_bdat};  // data bytes arrive MSB first
          r_idx    <= r_idx + 1'b1;
        end
      end else if (w_tmo) begin
        r_ferr  <= 1'b1;
        r_ecode <= E_TMO;
        r_idx   <= '0;
      end
    end
  end

  assign fcmd  = r_fcmd;
  assign fdat  = r_fdat;
  assign fok   = r_fok;
  assign ferr  = r_ferr;
  assign ecode = r_ecode;
  assign busy  = w_bact || (r_idx != '0);

endmodule

// File: tb/tb_prot_rx.sv
// Directed bench for prot_rx at 16 clocks per bit, 20 bit-time timeout.
module tb_prot_rx;

  localparam int CPB = 16;
  localparam int TMO = 20;

  logic        ck    = 1'b0;
  logic        rst_n = 1'b0;
  logic        Rx    = 1'b1;
  logic [7:0]  fcmd;
  logic [31:0] fdat;
  logic        fok;
  logic        ferr;
  logic [1:0]  ecode;
  logic        busy;

  prot_rx #(
    .CLKS_PER_BIT(CPB),
    .TIMEOUT_BITS(TMO)
  ) dut (
    .ck   (ck),
    .rst_n(rst_n),
    .Rx   (Rx),
    .fcmd (fcmd),
    .fdat (fdat),
    .fok  (fok),
    .ferr (ferr),
    .ecode(ecode),
    .busy (busy)
  );

  always #5 ck = ~ck;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  int         fok_cnt       = 0;
  int         ferr_cnt      = 0;
  int         last_fok_cyc  = 0;
  int         last_ferr_cyc = 0;
  int         overlap_cnt   = 0;
  logic       fok_d         = 1'b0;
  logic       ferr_d        = 1'b0;
  int         last_start    = 0;

  // cycle index of each rising edge
  always @(posedge ck) cyc <= cyc + 1;

  // strobe monitor, sampled mid-cycle
  always @(negedge ck) begin
    if (fok) begin
      fok_cnt++;
      last_fok_cyc = cyc;
    end
    if (ferr) begin
      ferr_cnt++;
      last_ferr_cyc = cyc;
    end
    if ((fok && ferr) || (fok && fok_d) || (ferr && ferr_d)) overlap_cnt++;
    fok_d  = fok;
    ferr_d = ferr;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bit_time(input logic v);
    Rx = v;
    repeat (CPB) @(posedge ck);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    last_start = cyc + 1;
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop_v);
    $display("byte %02h stop=%0d start_cyc=%0d", b, stop_v, last_start);
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [31:0] d);
    send_byte(8'hAA, 1'b1);
    send_byte(c, 1'b1);
    send_byte(d[31:24], 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
  endtask

  task automatic idle(input int n);
    Rx = 1'b1;
    repeat (n) @(posedge ck);
    #1;
  endtask

  int e0, f0, t0;

  initial begin
    repeat (4) @(posedge ck);
    #1;
    check("rst_fcmd", {24'h0, fcmd}, 32'h0);
    check("rst_fdat", fdat, 32'h0);
    check("rst_strobes", {30'h0, fok, ferr}, 32'h0);
    check("rst_ecode", {30'h0, ecode}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    rst_n = 1'b1;
    idle(20);

    // single zero-data frame, with latency from the last start edge
    send_frame(8'h0D, 32'h0);
    idle(4);
    check("f1_fok_cnt", fok_cnt, 1);
    check("f1_ferr_cnt", ferr_cnt, 0);
    check("f1_fcmd", {24'h0, fcmd}, 32'h0D);
    check("f1_fdat", fdat, 32'h0);
    check("f1_latency", last_fok_cyc - last_start, 155);
    check("f1_busy", {31'h0, busy}, 32'h0);

    // two back-to-back frames
    f0 = fok_cnt;
    send_frame(8'h09, 32'h12345678);
    check("b2b_fcmd_a", {24'h0, fcmd}, 32'h09);
    check("b2b_fdat_a", fdat, 32'h12345678);
    t0 = last_fok_cyc;
    send_frame(8'h01, 32'hDEADBEEF);
    idle(4);
    check("b2b_fok_cnt", fok_cnt - f0, 2);
    check("b2b_spacing", last_fok_cyc - t0, 60 * CPB);
    check("b2b_fcmd_b", {24'h0, fcmd}, 32'h01);
    check("b2b_fdat_b", fdat, 32'hDEADBEEF);
    check("b2b_ferr_cnt", ferr_cnt, 0);

    // bad header then good frame
    e0 = ferr_cnt;
    f0 = fok_cnt;
    send_byte(8'h55, 1'b1);
    idle(4);
    check("hdr_ferr_cnt", ferr_cnt - e0, 1);
    check("hdr_ecode", {30'h0, ecode}, 32'd2);
    check("hdr_busy", {31'h0, busy}, 32'h0);
    check("hdr_fcmd_kept", {24'h0, fcmd}, 32'h01);
    send_frame(8'h09, 32'h00000001);
    idle(4);
    check("hdr_fok_cnt", fok_cnt - f0, 1);
    check("hdr_fcmd", {24'h0, fcmd}, 32'h09);
    check("hdr_fdat", fdat, 32'h1);
    check("hdr_ferr_after", ferr_cnt - e0, 1);

    // inter-byte timeout after three bytes
    e0 = ferr_cnt;
    f0 = fok_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h12, 1'b1);
    t0 = last_start;
    idle(10 * CPB);
    check("tmo_busy_mid", {31'h0, busy}, 32'h1);
    idle(12 * CPB);
    check("tmo_ferr_cnt", ferr_cnt - e0, 1);
    check("tmo_ecode", {30'h0, ecode}, 32'd3);
    check("tmo_time", last_ferr_cyc - t0, 154 + TMO * CPB);
    check("tmo_fcmd", {24'h0, fcmd}, 32'h09);
    check("tmo_fdat", fdat, 32'h1);
    check("tmo_fok_cnt", fok_cnt - f0, 0);
    check("tmo_busy_end", {31'h0, busy}, 32'h0);

    // framing error on byte 3, then a short glitch
    e0 = ferr_cnt;
    f0 = fok_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h12, 1'b0);
    idle(4);
    check("frm_ferr_cnt", ferr_cnt - e0, 1);
    check("frm_ecode", {30'h0, ecode}, 32'd1);
    check("frm_fok_cnt", fok_cnt - f0, 0);
    idle(30 * CPB);
    Rx = 1'b0;
    repeat (4) @(posedge ck);
    #1;
    idle(40);
    $display("glitch done cyc=%0d", cyc);
    check("glt_ferr_cnt", ferr_cnt - e0, 1);
    check("glt_fok_cnt", fok_cnt - f0, 0);
    check("glt_busy", {31'h0, busy}, 32'h0);

    // reset during the data bits of byte 4
    e0 = ferr_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    repeat (5) @(posedge ck);
    #1;
    rst_n = 1'b0;
    Rx    = 1'b1;
    repeat (2) @(posedge ck);
    #1;
    check("mrst_fcmd", {24'h0, fcmd}, 32'h0);
    check("mrst_fdat", fdat, 32'h0);
    check("mrst_ecode", {30'h0, ecode}, 32'h0);
    check("mrst_busy", {31'h0, busy}, 32'h0);
    check("mrst_strobes", {30'h0, fok, ferr}, 32'h0);
    rst_n = 1'b1;
    idle(32);
    check("mrst_no_ferr", ferr_cnt - e0, 0);
    f0 = fok_cnt;
    send_frame(8'h0E, 32'hCAFEF00D);
    idle(4);
    check("post_fok_cnt", fok_cnt - f0, 1);
    check("post_fcmd", {24'h0, fcmd}, 32'h0E);
    check("post_fdat", fdat, 32'hCAFEF00D);
    check("post_ferr", ferr_cnt - e0, 0);

    check("strobe_overlap", overlap_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
